branch_predictor_btb: RTL and testbench
=======================================

Name: branch_predictor_btb

Overview:
Parametrised branch target buffer with saturating-counter direction prediction for the 5-stage RV32 pipeline. It replaces the fixed predict-not-taken policy, in which every taken BEQ flushes IF/ID and ID/EX. The IF stage looks up the current PC in the same cycle and gets a predicted direction and target. EX reports each resolved branch; the block trains its table, flags mispredictions and supplies the corrected PC.

Parameters:
- XLEN, 32, PC/target width.
- ENTRIES, 16, number of table entries; power of two, at least 2. IDX = log2(ENTRIES).
- CNT_BITS, 2, width of each saturating direction counter; at least 1.
- PERF_W, 32, width of the performance counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- if_pc  in  XLEN  PC currently being fetched.
- pred_taken  out  1  predict taken for if_pc (combinational).
- pred_target  out  XLEN  predicted target for if_pc (combinational).
- ex_valid  in  1  EX stage holds a real (non-bubble) instruction.
- ex_is_branch  in  1  EX instruction is a conditional branch.
- ex_pc  in  XLEN  PC of the EX instruction.
- ex_taken  in  1  resolved branch outcome.
- ex_target  in  XLEN  resolved taken target (EX_pc + imm).
- ex_pred_taken  in  1  prediction made at fetch, piped down to EX.
- ex_pred_target  in  XLEN  predicted target, piped down to EX.
- mispredict  out  1  flush IF/ID and ID/EX; load redirect_pc (combinational).
- redirect_pc  out  XLEN  correct next PC when mispredict=1.
- branch_count  out  PERF_W  resolved branches since reset.
- mispredict_count  out  PERF_W  mispredictions since reset.

Behaviour:
- Entry layout: valid, tag = pc[XLEN-1:IDX+2], target[XLEN], counter[CNT_BITS]. Index = pc[IDX+1:2]; pc[1:0] is ignored.
- Lookup (0 latency, combinational on if_pc):
  - hit = valid && tag match.
  - pred_taken = hit && counter MSB.
  - pred_target = entry target on hit, else if_pc+4.
  - pred_target is defined even when pred_taken=0.
- Resolve is active when ex_valid && ex_is_branch; otherwise mispredict=0 and no table or counter update occurs.
  - mispredict = (ex_pred_taken != ex_taken) || (ex_taken && ex_pred_target != ex_target).
  - redirect_pc = ex_taken ? ex_target : ex_pc+4, driven every cycle, meaningful only when mispredict=1.
- Update at the clock edge when resolve is active (entry indexed by ex_pc):
  - Tag hit, taken: counter = min(counter+1, 2^CNT_BITS-1); target = ex_target.
  - Tag hit, not taken: counter = max(counter-1, 0); target unchanged.
  - Miss, taken: allocate and overwrite any aliasing entry. valid=1, tag from ex_pc, target=ex_target, counter=2^(CNT_BITS-1) (weakly taken).
  - Miss, not taken: no change; no allocation.
- Performance counters: branch_count increments on every resolve; mispredict_count increments when mispredict=1. Both wrap modulo 2^PERF_W.
- Simultaneous lookup and update of the same entry: lookup sees the pre-update contents; the new value is visible from the next cycle. No bypass.
- The block has no stall input. The pipeline must deassert ex_valid for bubbles and flushed slots, so each branch is trained exactly once.
- Reset takes one cycle and is synchronous:
  - All valid bits cleared; counters set to 2^(CNT_BITS-1)-1 (weakly not-taken); targets set to 0; perf counters cleared.
  - During reset, updates are suppressed.
  - After reset, pred_taken=0 and pred_target=if_pc+4 for every PC.
  - Reset asserted mid-operation discards any pending update in that cycle.
- Arithmetic: PC+4 wraps modulo 2^XLEN. Counter saturation must not wrap.

Test Plan:
1. Reset, then if_pc=0x100 → pred_taken=0, pred_target=0x104; branch_count=0, mispredict_count=0.
2. Resolve ex_pc=0x100, taken, ex_target=0x80, ex_pred_taken=0 → mispredict=1, redirect_pc=0x80. Next cycle if_pc=0x100 → pred_taken=1, pred_target=0x80; counter=2.
3. Resolve 0x100 not-taken twice with the prediction piped correctly from the fetch lookup:
   - first resolve: mispredict=1, redirect_pc=0x104; counter 2→1.
   - second resolve: mispredict=0; counter 1→0, saturates.
   - Lookup pred_taken=0. Three taken resolves follow: counter 0→1→2→3; a fourth holds at 3.
4. Aliasing, ENTRIES=16: train 0x40 taken→0x200, then resolve 0x80 (same index 0) taken→0x300 → lookup 0x40 misses (pred_target=0x44); lookup 0x80 gives pred_taken=1, pred_target=0x300.
5. Same cycle: if_pc=ex_pc=0x100 with an allocating taken resolve → the same-cycle lookup gives pred_taken=0; the next cycle gives pred_taken=1.
6. Target change: entry 0x100→0x80 predicted taken, resolve taken to 0x90 with ex_pred_target=0x80 → mispredict=1, redirect_pc=0x90; table target becomes 0x90. With ex_valid=0 or ex_is_branch=0 → no counter or perf change.

Source files
------------

// File: rtl/branch_predictor_btb.sv
// rtl/branch_predictor_btb.sv - branch target buffer with saturating-counter direction prediction
module branch_predictor_btb #(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 16,
    parameter int CNT_BITS = 2,
    parameter int PERF_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   if_pc,
    output logic              pred_taken,
    output logic [XLEN-1:0]   pred_target,
    input  logic              ex_valid,
    input  logic              ex_is_branch,
    input  logic [XLEN-1:0]   ex_pc,
    input  logic              ex_taken,
    input  logic [XLEN-1:0]   ex_target,
    input  logic              ex_pred_taken,
    input  logic [XLEN-1:0]   ex_pred_target,
    output logic              mispredict,
    output logic [XLEN-1:0]   redirect_pc,
    output logic [PERF_W-1:0] branch_count,
    output logic [PERF_W-1:0] mispredict_count
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX - 2;

    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};
    localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(1 << (CNT_BITS - 1));
    localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_WT - CNT_ONE;
    localparam logic [XLEN-1:0]     PC_STEP = XLEN'(4);

    logic                valid_q  [ENTRIES];
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [XLEN-1:0]     target_q [ENTRIES];
    logic [CNT_BITS-1:0] cnt_q    [ENTRIES];

    logic [IDX-1:0]   look_idx;
    logic [TAG_W-1:0] look_tag;
    logic             look_hit;
    logic [IDX-1:0]   upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic             resolve;

    // Byte-offset bits of the PCs carry no information for 4-byte aligned fetch.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

    // Fetch-side lookup: reads the table as it stood before this cycle's update.
    always_comb begin
        look_idx    = if_pc[IDX+1:2];
        look_tag    = if_pc[XLEN-1:IDX+2];
        look_hit    = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
        pred_taken  = look_hit && cnt_q[look_idx][CNT_BITS-1];
        pred_target = look_hit ? target_q[look_idx] : (if_pc + PC_STEP);
    end

    // Resolve-side compare: direction error, or taken to a different target.
    always_comb begin
        resolve     = ex_valid && ex_is_branch;
        upd_idx     = ex_pc[IDX+1:2];
        upd_tag     = ex_pc[XLEN-1:IDX+2];
        upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        mispredict  = resolve && ((ex_pred_taken != ex_taken) ||
                                  (ex_taken && (ex_pred_target != ex_target)));
        redirect_pc = ex_taken ? ex_target : (ex_pc + PC_STEP);
    end

    // Table training: saturate on hits, allocate only on taken misses.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_WNT;
            end
        end else if (resolve) begin
            if (upd_hit) begin
                if (ex_taken) begin
                    target_q[upd_idx] <= ex_target;
                    if (cnt_q[upd_idx] != CNT_MAX) begin
                        cnt_q[upd_idx] <= cnt_q[upd_idx] + CNT_ONE;
                    end
                end else if (cnt_q[upd_idx] != '0) begin
                    cnt_q[upd_idx] <= cnt_q[upd_idx] - CNT_ONE;
                end
            end else if (ex_taken) begin
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= ex_target;
                cnt_q[upd_idx]    <= CNT_WT;
            end
        end
    end

    // Performance counters, free-running modulo 2^PERF_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (resolve) begin
            branch_count <= branch_count + PERF_W'(1);
            if (mispredict) begin
                mispredict_count <= mispredict_count + PERF_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// tb/tb_branch_predictor_btb.sv - directed self-checking bench for branch_predictor_btb
module tb_branch_predictor_btb;

    logic        clk;
    logic        reset;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int n_chk;
    int n_fail;
    int exp_br;
    int exp_mp;

    branch_predictor_btb dut (
        .clk              (clk),
        .reset            (reset),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .ex_valid         (ex_valid),
        .ex_is_branch     (ex_is_branch),
        .ex_pc            (ex_pc),
        .ex_taken         (ex_taken),
        .ex_target        (ex_target),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_target   (ex_pred_target),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic pt, input logic [31:0] ptg);
        if_pc = pc;
        #1;
        chk({tag, "_pt"}, {31'b0, pred_taken}, {31'b0, pt});
        chk({tag, "_ptg"}, pred_target, ptg);
    endtask

    task automatic drive(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic pt, input logic [31:0] ptg);
        ex_valid       = 1'b1;
        ex_is_branch   = 1'b1;
        ex_pc          = pc;
        ex_taken       = tk;
        ex_target      = tgt;
        ex_pred_taken  = pt;
        ex_pred_target = ptg;
    endtask

    task automatic commit(input string tag, input logic mp);
        tick();
        ex_valid = 1'b0;
        exp_br++;
        if (mp) exp_mp++;
        chk({tag, "_brc"}, branch_count, exp_br);
        chk({tag, "_mpc"}, mispredict_count, exp_mp);
    endtask

    task automatic res(input string tag, input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic pt, input logic [31:0] ptg, input logic mp, input logic [31:0] rd);
        drive(pc, tk, tgt, pt, ptg);
        #1;
        chk({tag, "_mp"}, {31'b0, mispredict}, {31'b0, mp});
        chk({tag, "_rd"}, redirect_pc, rd);
        commit(tag, mp);
    endtask

    initial begin
        n_chk = 0; n_fail = 0; exp_br = 0; exp_mp = 0;
        reset = 1'b1; if_pc = 32'h0;
        ex_valid = 1'b0; ex_is_branch = 1'b0; ex_pc = 32'h0; ex_taken = 1'b0;
        ex_target = 32'h0; ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
        tick();
        tick();
        reset = 1'b0;

        // reset state
        look("rst", 32'h100, 1'b0, 32'h104);
        chk("rst_brc", branch_count, 32'd0);
        chk("rst_mpc", mispredict_count, 32'd0);
        chk("rst_mp", {31'b0, mispredict}, 32'd0);

        // allocate on taken miss; same-cycle lookup still sees the old contents
        if_pc = 32'h100;
        drive(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        #1;
        chk("alloc_mp", {31'b0, mispredict}, 32'd1);
        chk("alloc_rd", redirect_pc, 32'h80);
        chk("alloc_same_pt", {31'b0, pred_taken}, 32'd0);
        commit("alloc", 1'b1);
        look("alloc_next", 32'h100, 1'b1, 32'h80);

        // counter walks down to 0, back up, and saturates at 3
        res("nt1", 32'h100, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h104);
        look("nt1_l", 32'h100, 1'b0, 32'h80);
        res("nt2", 32'h100, 1'b0, 32'h80, 1'b0, 32'h80, 1'b0, 32'h104);
        look("nt2_l", 32'h100, 1'b0, 32'h80);
        res("t1", 32'h100, 1'b1, 32'h80, 1'b0, 32'h80, 1'b1, 32'h80);
        look("t1_l", 32'h100, 1'b0, 32'h80);
        res("t2", 32'h100, 1'b1, 32'h80, 1'b0, 32'h80, 1'b1, 32'h80);
        look("t2_l", 32'h100, 1'b1, 32'h80);
        res("t3", 32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h80);
        res("t4", 32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h80);
        res("nt_sat", 32'h100, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h104);
        look("nt_sat_l", 32'h100, 1'b1, 32'h80);

        // taken to a new target: counter 2->3, target replaced
        res("tchg", 32'h100, 1'b1, 32'h90, 1'b1, 32'h80, 1'b1, 32'h90);
        look("tchg_l", 32'h100, 1'b1, 32'h90);

        // gated resolves train nothing and count nothing
        drive(32'h100, 1'b0, 32'h90, 1'b1, 32'h90);
        ex_valid = 1'b0;
        #1;
        chk("gate_v_mp", {31'b0, mispredict}, 32'd0);
        tick();
        ex_valid = 1'b1;
        ex_is_branch = 1'b0;
        #1;
        chk("gate_b_mp", {31'b0, mispredict}, 32'd0);
        tick();
        ex_valid = 1'b0;
        chk("gate_brc", branch_count, exp_br);
        chk("gate_mpc", mispredict_count, exp_mp);
        look("gate_l", 32'h100, 1'b1, 32'h90);

        // aliasing at index 0
        res("a40", 32'h40, 1'b1, 32'h200, 1'b0, 32'h44, 1'b1, 32'h200);
        look("a40_l", 32'h40, 1'b1, 32'h200);
        res("a80", 32'h80, 1'b1, 32'h300, 1'b0, 32'h84, 1'b1, 32'h300);
        look("a80_l40", 32'h40, 1'b0, 32'h44);
        look("a80_l80", 32'h80, 1'b1, 32'h300);
        look("a80_l82", 32'h82, 1'b1, 32'h300);

        // not-taken miss allocates nothing
        res("mnt", 32'h200, 1'b0, 32'h500, 1'b0, 32'h204, 1'b0, 32'h204);
        look("mnt_l80", 32'h80, 1'b1, 32'h300);
        look("mnt_l200", 32'h200, 1'b0, 32'h204);

        // PC+4 wraps
        look("wrap_l", 32'hFFFF_FFFC, 1'b0, 32'h0);
        res("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

        // reset mid-operation drops the pending allocation
        drive(32'h140, 1'b1, 32'h600, 1'b0, 32'h144);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ex_valid = 1'b0;
        chk("mid_rst_brc", branch_count, 32'd0);
        chk("mid_rst_mpc", mispredict_count, 32'd0);
        look("mid_rst_140", 32'h140, 1'b0, 32'h144);
        look("mid_rst_80", 32'h80, 1'b0, 32'h84);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
